// File: rtl/i2c_reg_slave_pkg.sv
// Shared constants for the I2C register target: FSM state encodings and bus bit meanings.
package i2c_pkg;
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_ADDR     = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK = 4'd2;
    localparam logic [3:0] ST_PTR      = 4'd3;
    localparam logic [3:0] ST_PTR_ACK  = 4'd4;
    localparam logic [3:0] ST_WR       = 4'd5;
    localparam logic [3:0] ST_WR_ACK   = 4'd6;
    localparam logic [3:0] ST_RD       = 4'd7;
    localparam logic [3:0] ST_RD_ACK   = 4'd8;

    localparam logic ACK     = 1'b0;
    localparam logic NACK    = 1'b1;
    localparam logic RW_READ = 1'b1;
endpackage

// File: rtl/i2c_reg_slave_if.sv
// Register-port bundle between the I2C target and the local register logic.
interface i2c_reg_slave_if #(parameter int PTR_W = 8) ();
    logic [6:0]       addr;
    logic             busy;
    logic [PTR_W-1:0] reg_ptr;
    logic [7:0]       reg_wdata;
    logic             reg_we;
    logic             reg_re;
    logic [7:0]       reg_rdata;

    modport slave  (input addr, reg_rdata, output busy, reg_ptr, reg_wdata, reg_we, reg_re);
    modport master (output addr, reg_rdata, input busy, reg_ptr, reg_wdata, reg_we, reg_re);
endinterface

// File: rtl/i2c_reg_slave_line_cond.sv
// Brings SCL/SDA into the clk domain and derives bus edges plus START/STOP conditions.
// Optional 3-sample glitch filter enabled by defining I2C_REG_SLAVE_GLITCH_FILTER_EN.
module i2c_line_cond #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_raw,
    input  logic sda_raw,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_c, sda_c, scl_d, sda_d;

    // Synchronisers reset to the idle-high bus level so reset release creates no edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_raw};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_raw};
        end
    end

`ifdef I2C_REG_SLAVE_GLITCH_FILTER_EN
    logic [1:0] scl_hist, sda_hist;
    logic       scl_f, sda_f;

    // A level is accepted only after three consecutive equal samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[SYNC_STAGES-1]};
            sda_hist <= {sda_hist[0], sda_sync[SYNC_STAGES-1]};
            if ({scl_hist, scl_sync[SYNC_STAGES-1]} == 3'b111) scl_f <= 1'b1;
            else if ({scl_hist, scl_sync[SYNC_STAGES-1]} == 3'b000) scl_f <= 1'b0;
            if ({sda_hist, sda_sync[SYNC_STAGES-1]} == 3'b111) sda_f <= 1'b1;
            else if ({sda_hist, sda_sync[SYNC_STAGES-1]} == 3'b000) sda_f <= 1'b0;
        end
    end

    assign scl_c = scl_f;
    assign sda_c = sda_f;
`else
    assign scl_c = scl_sync[SYNC_STAGES-1];
    assign sda_c = sda_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_c;
            sda_d <= sda_c;
        end
    end

    assign scl_s     = scl_c;
    assign sda_s     = sda_c;
    assign scl_rise  = scl_c & ~scl_d;
    assign scl_fall  = ~scl_c & scl_d;
    assign start_det = scl_c & scl_d & sda_d & ~sda_c;
    assign stop_det  = scl_c & scl_d & ~sda_d & sda_c;
endmodule

// File: rtl/i2c_reg_slave.sv
// I2C register target: 7-bit address, pointer write, burst read/write with pointer auto-increment.
// Optional SCL/SDA glitch filter enabled by defining I2C_REG_SLAVE_GLITCH_FILTER_EN.
module i2c_reg_slave
    import i2c_pkg::*;
#(
    parameter int PTR_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    i2c_reg_slave_if.slave bus,
    input  logic           SCL,
    inout  wire            SDA
);
    logic             scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic             bit_sample;
    logic [3:0]       state;
    logic [3:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             rw, sda_oe, busy_q, we_q, re_q, re_next, rd_cap;
    logic [7:0]       wdata_q;
    logic [PTR_W-1:0] ptr_q;

    i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_line_cond (
        .clk       (clk),
        .rst       (rst),
        .scl_raw   (SCL),
        .sda_raw   (SDA),
        .scl_s     (scl_s),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign bit_sample    = scl_rise & scl_s;
    assign SDA           = sda_oe ? 1'b0 : 1'bz;
    assign bus.busy      = busy_q;
    assign bus.reg_ptr   = ptr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_we    = we_q;
    assign bus.reg_re    = re_q;

    // SDA enable is a flop with async reset, so reset releases the line without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            rw      <= 1'b0;
            sda_oe  <= 1'b0;
            busy_q  <= 1'b0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            re_next <= 1'b0;
            rd_cap  <= 1'b0;
            ptr_q   <= '0;
        end else begin
            we_q    <= 1'b0;
            re_q    <= re_next;
            re_next <= 1'b0;
            rd_cap  <= re_q;
            if (we_q) ptr_q <= ptr_q + PTR_W'(1);
            if (rd_cap) shreg <= bus.reg_rdata;

            if (stop_det) begin
                state   <= ST_IDLE;
                sda_oe  <= 1'b0;
                busy_q  <= 1'b0;
                bit_cnt <= '0;
            end else if (start_det) begin
                state   <= ST_ADDR;
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    ST_ADDR, ST_PTR, ST_WR: begin
                        if (bit_sample) begin
                            shreg   <= {shreg[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if (state == ST_ADDR) begin
                                if (shreg[7:1] == bus.addr) begin
                                    state  <= ST_ADDR_ACK;
                                    sda_oe <= 1'b1;
                                    busy_q <= 1'b1;
                                    rw     <= shreg[0];
                                end else begin
                                    state  <= ST_IDLE;
                                    busy_q <= 1'b0;
                                end
                            end else if (state == ST_PTR) begin
                                state  <= ST_PTR_ACK;
                                sda_oe <= 1'b1;
                                ptr_q  <= PTR_W'(shreg);
                            end else begin
                                state   <= ST_WR_ACK;
                                sda_oe  <= 1'b1;
                                wdata_q <= shreg;
                                we_q    <= 1'b1;
                            end
                        end
                    end
                    // A read fetches its first byte while the master samples the address ACK.
                    ST_ADDR_ACK: begin
                        if (bit_sample && rw == RW_READ) begin
                            state   <= ST_RD;
                            re_q    <= 1'b1;
                            bit_cnt <= '0;
                        end else if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= ST_PTR;
                        end
                    end
                    ST_PTR_ACK, ST_WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= ST_WR;
                        end
                    end
                    ST_RD: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= ST_RD_ACK;
                            end else begin
                                sda_oe  <= ~shreg[7];
                                shreg   <= {shreg[6:0], 1'b0};
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (bit_sample) begin
                            case (sda_s)
                                ACK: begin
                                    ptr_q   <= ptr_q + PTR_W'(1);
                                    re_next <= 1'b1;
                                    state   <= ST_RD;
                                end
                                NACK: begin
                                    state  <= ST_IDLE;
                                    busy_q <= 1'b0;
                                end
                                default: ;
                            endcase
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
